// File: rtl/biquad_coef_loader_pkg.sv
// Shared constants for the biquad coefficient loader: per-section layout,
// FSM state encodings and the Q2.14 unity value.
package biquad_coef_loader_pkg;

    localparam int unsigned COEF_PER_SECT = 5;

    localparam int unsigned IDX_B0 = 0;
    localparam int unsigned IDX_B1 = 1;
    localparam int unsigned IDX_B2 = 2;
    localparam int unsigned IDX_A1 = 3;
    localparam int unsigned IDX_A2 = 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_PENDING = 2'd3;

    localparam logic signed [15:0] COEF_ONE = 16'sh4000;

endpackage

// File: rtl/biquad_coef_loader_if.sv
// Coefficient word stream: valid/ready handshake carrying one signed word
// plus an end-of-frame marker.
interface biquad_coef_loader_if #(
    parameter int unsigned COEF_W = 16
);
    logic              wr_valid;
    logic              wr_ready;
    logic [COEF_W-1:0] wr_data;
    logic              wr_last;

    modport master (output wr_valid, output wr_data, output wr_last, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, input  wr_last, output wr_ready);
endinterface

// File: rtl/biquad_coef_loader_coef_bank.sv
// Shadow/active coefficient register pairs. Shadow is written word by word;
// commit copies the whole shadow into active on one edge, revert throws the
// shadow away by reloading it from active. Both banks reset to passthrough.
module coef_bank
    import biquad_coef_loader_pkg::*;
#(
    parameter int unsigned              NUM_WORDS = 10,
    parameter int unsigned              COEF_W    = 16,
    parameter int unsigned              ADDR_W    = 4,
    parameter logic signed [COEF_W-1:0] COEF_ONE  = 16'sh4000
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  wr_en_i,
    input  logic [ADDR_W-1:0]                     wr_addr_i,
    input  logic [COEF_W-1:0]                     wr_data_i,
    input  logic                                  commit_i,
    input  logic                                  revert_i,
    output logic [NUM_WORDS-1:0][COEF_W-1:0]      active_o
);

    function automatic logic [NUM_WORDS-1:0][COEF_W-1:0] unity_bank();
        logic [NUM_WORDS-1:0][COEF_W-1:0] v;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            v[i] = ((i % COEF_PER_SECT) == IDX_B0) ? COEF_ONE : '0;
        end
        return v;
    endfunction

    localparam logic [NUM_WORDS-1:0][COEF_W-1:0] UNITY = unity_bank();

    logic [NUM_WORDS-1:0][COEF_W-1:0] shadow_q, shadow_d;
    logic [NUM_WORDS-1:0][COEF_W-1:0] active_q, active_d;

    // Next-state for both banks: revert beats a same-cycle word write.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (commit_i) begin
            active_d = shadow_q;
        end
        if (revert_i) begin
            shadow_d = active_q;
        end else if (wr_en_i) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                if (wr_addr_i == ADDR_W'(i)) begin
                    shadow_d[i] = wr_data_i;
                end
            end
        end
    end

    // Bank registers with asynchronous reset to unity passthrough.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= UNITY;
            active_q <= UNITY;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/biquad_coef_loader.sv
// Coefficient loader for the cascaded biquad: collects a frame of words into
// a shadow bank and commits it atomically on the next sample strobe.
module biquad_coef_loader #(
    parameter int unsigned              NUM_SECT = 2,
    parameter int unsigned              COEF_W   = 16,
    parameter logic signed [COEF_W-1:0] COEF_ONE = biquad_coef_loader_pkg::COEF_ONE
) (
    input  logic                        CLK,
    input  logic                        RST,
    biquad_coef_loader_if.slave         wr,
    input  logic                        abort,
    input  logic                        smp_stb,
    input  logic                        err_clr,
    output logic [NUM_SECT*biquad_coef_loader_pkg::COEF_PER_SECT*COEF_W-1:0] coef,
    output logic                        coef_upd,
    output logic                        busy,
    output logic                        err,
    output logic signed [COEF_W-1:0]    b_0 [NUM_SECT],
    output logic signed [COEF_W-1:0]    b_1 [NUM_SECT],
    output logic signed [COEF_W-1:0]    b_2 [NUM_SECT],
    output logic signed [COEF_W-1:0]    a_1 [NUM_SECT],
    output logic signed [COEF_W-1:0]    a_2 [NUM_SECT]
);
    import biquad_coef_loader_pkg::*;

    localparam int unsigned      FRAME_LEN = COEF_PER_SECT * NUM_SECT;
    localparam int unsigned      IDX_W     = $clog2(FRAME_LEN + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             upd_q, upd_d;
    logic             xfer, wr_en, commit, revert, err_set;

    assign wr.wr_ready = (state_q != S_PENDING);
    assign xfer        = wr.wr_valid & wr.wr_ready;

    // Frame FSM: abort outranks any transfer or strobe outside IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        revert  = 1'b0;
        err_set = 1'b0;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            revert  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        wr_en = 1'b1;
                        idx_d = IDX_W'(1);
                        if (FRAME_LEN == 1) begin
                            // A one-word frame is judged on its first word.
                            if (wr.wr_last) begin
                                state_d = S_PENDING;
                            end else begin
                                err_set = 1'b1;
                                revert  = 1'b1;
                                state_d = S_DRAIN;
                            end
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        if (idx_q == IDX_LAST) begin
                            if (wr.wr_last) begin
                                wr_en   = 1'b1;
                                state_d = S_PENDING;
                            end else begin
                                err_set = 1'b1;
                                revert  = 1'b1;
                                state_d = S_DRAIN;
                            end
                        end else if (wr.wr_last) begin
                            err_set = 1'b1;
                            revert  = 1'b1;
                            idx_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            wr_en = 1'b1;
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (xfer && wr.wr_last) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    if (smp_stb) begin
                        commit  = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
        upd_d = commit;
    end

    // Control registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
        end
    end

    coef_bank #(
        .NUM_WORDS (FRAME_LEN),
        .COEF_W    (COEF_W),
        .ADDR_W    (IDX_W),
        .COEF_ONE  (COEF_ONE)
    ) u_bank (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .wr_en_i   (wr_en),
        .wr_addr_i (idx_q),
        .wr_data_i (wr.wr_data),
        .commit_i  (commit),
        .revert_i  (revert),
        .active_o  (coef)
    );

    assign coef_upd = upd_q;
    assign busy     = (state_q != S_IDLE);
    assign err      = err_q;

    for (genvar s = 0; s < NUM_SECT; s++) begin : g_sect
        assign b_0[s] = coef[(COEF_PER_SECT*s + IDX_B0)*COEF_W +: COEF_W];
        assign b_1[s] = coef[(COEF_PER_SECT*s + IDX_B1)*COEF_W +: COEF_W];
        assign b_2[s] = coef[(COEF_PER_SECT*s + IDX_B2)*COEF_W +: COEF_W];
        assign a_1[s] = coef[(COEF_PER_SECT*s + IDX_A1)*COEF_W +: COEF_W];
        assign a_2[s] = coef[(COEF_PER_SECT*s + IDX_A2)*COEF_W +: COEF_W];
    end

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Directed bench for biquad_coef_loader (2 sections, 16-bit coefficients).
module tb_biquad_coef_loader;
    localparam int NS = 2;
    localparam int W  = 16;
    localparam int FL = 5 * NS;
    localparam int BW = FL * W;

    logic          CLK = 1'b0;
    logic          RST;
    logic          abort, smp_stb, err_clr;
    logic [BW-1:0] coef;
    logic          coef_upd, busy, err;
    logic signed [W-1:0] b_0 [NS];
    logic signed [W-1:0] b_1 [NS];
    logic signed [W-1:0] b_2 [NS];
    logic signed [W-1:0] a_1 [NS];
    logic signed [W-1:0] a_2 [NS];

    biquad_coef_loader_if #(.COEF_W(W)) bus ();

    biquad_coef_loader #(
        .NUM_SECT (NS),
        .COEF_W   (W),
        .COEF_ONE (16'sh4000)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wr       (bus),
        .abort    (abort),
        .smp_stb  (smp_stb),
        .err_clr  (err_clr),
        .coef     (coef),
        .coef_upd (coef_upd),
        .busy     (busy),
        .err      (err),
        .b_0      (b_0),
        .b_1      (b_1),
        .b_2      (b_2),
        .a_1      (a_1),
        .a_2      (a_2)
    );

    always #5 CLK = ~CLK;

    int errors   = 0;
    int checks   = 0;
    int accepted = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] unity_pat();
        logic [BW-1:0] v;
        v = '0;
        v[0*W +: W] = 16'h4000;
        v[5*W +: W] = 16'h4000;
        return v;
    endfunction

    function automatic logic [BW-1:0] ramp_pat(input int base);
        logic [BW-1:0] v;
        for (int i = 0; i < FL; i++) v[i*W +: W] = 16'(base + i);
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic last);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_last  = last;
        if (bus.wr_ready) accepted++;
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #3;
        RST = 1'b1;
        tick();
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < FL; i++) send(16'(base + i), (i == FL - 1));
    endtask

    initial begin
        RST          = 1'b0;
        abort        = 1'b0;
        smp_stb      = 1'b0;
        err_clr      = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_last  = 1'b0;
        #12;
        RST = 1'b1;
        tick();

        // Reset state
        check("rst_coef",  coef, unity_pat());
        check("rst_ready", bus.wr_ready, 1);
        check("rst_busy",  busy, 0);
        check("rst_err",   err, 0);
        check("rst_upd",   coef_upd, 0);
        check("rst_b0_s1", b_0[1], 16'h4000);

        // Good frame 1..10, strobe three cycles later
        send_frame(1);
        check("pend_ready", bus.wr_ready, 0);
        check("pend_busy",  busy, 1);
        check("pend_coef",  coef, unity_pat());
        for (int c = 0; c < 3; c++) begin
            tick();
            check("wait_coef", coef, unity_pat());
            check("wait_upd",  coef_upd, 0);
        end
        smp_stb = 1'b1;
        tick();
        smp_stb = 1'b0;
        check("commit_coef", coef, ramp_pat(1));
        check("commit_upd",  coef_upd, 1);
        check("commit_a2s1", a_2[1], 16'd10);
        check("commit_b0s0", b_0[0], 16'd1);
        check("commit_a1s0", a_1[0], 16'd4);
        check("commit_busy", busy, 0);
        tick();
        check("upd_single",  coef_upd, 0);
        check("coef_hold",   coef, ramp_pat(1));

        // Short frame: wr_last on word 4
        do_reset();
        for (int i = 1; i <= 4; i++) send(16'(i), (i == 4));
        check("short_err",    err, 1);
        check("short_busy",   busy, 0);
        check("short_coef",   coef, unity_pat());
        check("short_shadow", dut.u_bank.shadow_q, unity_pat());
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("errclr", err, 0);

        // Long frame: 10 words without wr_last (err_clr collides with the error), then 3 more
        accepted = 0;
        for (int i = 0; i < FL; i++) begin
            if (i == FL - 1) err_clr = 1'b1;
            send(16'(11 + i), 1'b0);
            err_clr = 1'b0;
        end
        check("long_err",   err, 1);
        check("long_drain", busy, 1);
        send(16'd21, 1'b0);
        send(16'd22, 1'b0);
        send(16'd23, 1'b1);
        check("long_accepted", accepted, 13);
        check("long_busy",     busy, 0);
        check("long_coef",     coef, unity_pat());
        check("long_upd",      coef_upd, 0);
        check("long_shadow",   dut.u_bank.shadow_q, unity_pat());

        // Abort with a same-cycle strobe in PENDING
        send_frame(1);
        check("abt_pend", busy, 1);
        abort   = 1'b1;
        smp_stb = 1'b1;
        tick();
        abort   = 1'b0;
        smp_stb = 1'b0;
        check("abt_busy", busy, 0);
        check("abt_coef", coef, unity_pat());
        check("abt_upd0", coef_upd, 0);
        tick();
        check("abt_upd1",   coef_upd, 0);
        check("abt_shadow", dut.u_bank.shadow_q, unity_pat());

        // Final word together with smp_stb: commit waits for the next strobe
        for (int i = 0; i < FL; i++) begin
            if (i == FL - 1) smp_stb = 1'b1;
            send(16'(256 + i), (i == FL - 1));
            smp_stb = 1'b0;
        end
        check("fin_busy", busy, 1);
        check("fin_coef", coef, unity_pat());
        check("fin_upd",  coef_upd, 0);
        tick();
        check("fin_hold", coef, unity_pat());
        smp_stb = 1'b1;
        tick();
        smp_stb = 1'b0;
        check("fin_commit", coef, ramp_pat(256));
        check("fin_upd2",   coef_upd, 1);

        // Asynchronous reset in the middle of a load
        send(16'h0055, 1'b0);
        send(16'h0056, 1'b0);
        send(16'h0057, 1'b0);
        check("mid_busy",  busy, 1);
        check("mid_err",   err, 1);
        #3;
        RST = 1'b0;
        #1;
        check("arst_coef",  coef, unity_pat());
        check("arst_ready", bus.wr_ready, 1);
        check("arst_busy",  busy, 0);
        check("arst_err",   err, 0);
        check("arst_upd",   coef_upd, 0);
        #3;
        RST = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
